// File: rtl/data_sram_like_slave.sv
// Data-side SRAM-like slave: accepts load/store requests into a word array and
// returns in-order data_ok/rdata responses after a programmable minimum latency.
module data_sram_like_slave #(
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    input  logic        resp_stall
);

    localparam int unsigned DEPTH      = 1 << MEM_AW;
    localparam int unsigned PW         = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CW         = PW + 1;
    localparam logic [3:0]  TIMER_INIT = 4'(LATENCY - 1);

    logic [31:0]       mem        [DEPTH];
    logic [31:0]       fifo_data  [OUTSTANDING];
    logic [3:0]        fifo_timer [OUTSTANDING];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic [MEM_AW-1:0] word_idx;
    logic              accept;
    logic              head_ready;
    logic              fire;
    logic [31:0]       acc_data;
    logic [31:0]       head_data;
    logic [31:0]       store_word;
    logic [3:0]        head_timer_nxt;
    logic              unused_bits;

    assign unused_bits = ^{size, addr[31:MEM_AW+2], addr[1:0]};

    assign addr_ok  = !reset && (count != CW'(OUTSTANDING));
    assign accept   = req && addr_ok;
    assign word_idx = addr[MEM_AW+1:2];

    // Byte-lane merge of the store into the addressed word.
    always_comb begin
        store_word = mem[word_idx];
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                store_word[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Head selection; the decision uses the timer after this cycle's decrement so
    // the registered data_ok lands exactly LATENCY cycles after acceptance.
    always_comb begin
        acc_data       = wr ? 32'h0 : mem[word_idx];
        head_ready     = 1'b0;
        head_data      = fifo_data[rd_ptr];
        head_timer_nxt = (fifo_timer[rd_ptr] == 4'd0) ? 4'd0 : fifo_timer[rd_ptr] - 4'd1;
        if (count != CW'(0)) begin
            head_ready = (head_timer_nxt == 4'd0);
        end else if (accept && (TIMER_INIT == 4'd0)) begin
            head_ready = 1'b1;
            head_data  = acc_data;
        end
    end

    assign fire = head_ready && !resp_stall;

    // Word array: not reset, written at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            mem[word_idx] <= store_word;
        end
    end

    // Response FIFO, occupancy and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            data_ok <= 1'b0;
            rdata   <= '0;
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                fifo_timer[i] <= 4'd0;
            end
        end else begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                fifo_timer[i] <= (fifo_timer[i] == 4'd0) ? 4'd0 : fifo_timer[i] - 4'd1;
            end
            if (accept) begin
                fifo_data[wr_ptr]  <= acc_data;
                fifo_timer[wr_ptr] <= TIMER_INIT;
                wr_ptr             <= wr_ptr + PW'(1);
            end
            if (fire) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (accept && !fire) begin
                count <= count + CW'(1);
            end else if (fire && !accept) begin
                count <= count - CW'(1);
            end
            data_ok <= fire;
            rdata   <= fire ? head_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_data_sram_like_slave.sv
// Randomized bench for data_sram_like_slave: two instances (LATENCY 2 and 1) share
// stimulus and are each compared against a due-cycle queue model every cycle.
module tb_data_sram_like_slave;

    localparam int unsigned OUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        resp_stall;
    logic [1:0]  addr_ok_v;
    logic [1:0]  data_ok_v;
    logic [31:0] rdata_v [2];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          lat [2] = '{2, 1};

    logic [31:0] mem_m [2][1024];
    logic [31:0] qd [2][$];
    int          qt [2][$];
    logic [1:0]  exp_dok;
    logic [31:0] exp_rd [2];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;

    data_sram_like_slave #(.MEM_AW(10), .LATENCY(2), .OUTSTANDING(OUT)) dut_l2 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_v[0]), .data_ok(data_ok_v[0]),
        .rdata(rdata_v[0]), .resp_stall(resp_stall)
    );

    data_sram_like_slave #(.MEM_AW(10), .LATENCY(1), .OUTSTANDING(OUT)) dut_l1 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok_v[1]), .data_ok(data_ok_v[1]),
        .rdata(rdata_v[1]), .resp_stall(resp_stall)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, check addr_ok, advance the model, check the response.
    task automatic step(input logic rq, input logic w, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] wd,
                        input logic stall, input logic rst);
        logic        exp_aok;
        logic [9:0]  idx;
        logic [31:0] m;
        req = rq; wr = w; addr = a; wstrb = st; wdata = wd;
        resp_stall = stall; reset = rst; size = 2'($urandom_range(0, 2));
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_aok = !rst && (qd[d].size() < OUT);
            check($sformatf("addr_ok_L%0d", lat[d]), 32'(addr_ok_v[d]), 32'(exp_aok));
            exp_dok[d] = 1'b0;
            exp_rd[d]  = 32'h0;
            if (rst) begin
                qd[d].delete();
                qt[d].delete();
            end else begin
                if (rq && exp_aok) begin
                    idx = a[11:2];
                    m   = mem_m[d][idx];
                    if (w) begin
                        for (int i = 0; i < 4; i++) begin
                            if (st[i]) m[8*i +: 8] = wd[8*i +: 8];
                        end
                        mem_m[d][idx] = m;
                        qd[d].push_back(32'h0);
                    end else begin
                        qd[d].push_back(m);
                    end
                    qt[d].push_back(cyc + lat[d]);
                end
                if (!stall && qd[d].size() > 0 && qt[d][0] <= cyc + 1) begin
                    exp_dok[d] = 1'b1;
                    exp_rd[d]  = qd[d][0];
                    qd[d].delete(0);
                    qt[d].delete(0);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("data_ok_L%0d", lat[d]), 32'(data_ok_v[d]), 32'(exp_dok[d]));
            check($sformatf("rdata_L%0d", lat[d]), rdata_v[d], exp_rd[d]);
            if (data_ok_v[d]) last_rd[d] = rdata_v[d];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic stall);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, stall, 1'b0);
    endtask

    task automatic ld(input logic [31:0] a, input logic stall);
        step(1'b1, 1'b0, a, 4'h0, 32'h0, stall, 1'b0);
    endtask

    task automatic sto(input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                       input logic stall);
        step(1'b1, 1'b1, a, st, wd, stall, 1'b0);
    endtask

    initial begin
        logic [31:0] tmp;
        logic [3:0]  widx;
        req = 0; wr = 0; addr = 0; wstrb = 0; wdata = 0; resp_stall = 0; reset = 1; size = 0;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);

        // Initialise the words the bench will load from.
        for (int i = 0; i < 16; i++) sto(32'(i * 4), 4'hF, $urandom(), 1'b0);
        idle(4, 1'b0);

        // Store then load at 0x100.
        sto(32'h100, 4'hF, 32'h11223344, 1'b0);
        idle(2, 1'b0);
        ld(32'h100, 1'b0);
        idle(3, 1'b0);
        check("t1_load_l2", last_rd[0], 32'h11223344);
        check("t1_load_l1", last_rd[1], 32'h11223344);

        // Partial store over zero, aligned and unaligned loads.
        sto(32'h200, 4'hF, 32'h0, 1'b0);
        sto(32'h200, 4'b0101, 32'hAABBCCDD, 1'b0);
        ld(32'h200, 1'b0);
        idle(3, 1'b0);
        check("t2_load_l2", last_rd[0], 32'h00BB00DD);
        ld(32'h202, 1'b0);
        idle(3, 1'b0);
        check("t2_unaligned_l1", last_rd[1], 32'h00BB00DD);

        // Fill under stall, then release and drain in order.
        for (int i = 0; i < 4; i++) sto(32'(i * 4), 4'hF, 32'hA0 + 32'(i), 1'b0);
        idle(3, 1'b0);
        for (int i = 0; i < 4; i++) ld(32'(i * 4), 1'b1);
        idle(3, 1'b1);
        idle(6, 1'b0);
        check("t3_last_l2", last_rd[0], 32'hA3);
        check("t3_last_l1", last_rd[1], 32'hA3);

        // Full FIFO, stall released while req stays high.
        for (int i = 0; i < 4; i++) ld(32'(i * 4), 1'b1);
        for (int i = 0; i < 6; i++) ld(32'(i * 4), 1'b0);
        idle(4, 1'b0);

        // Back-to-back loads (continuous stream on the LATENCY 1 instance).
        for (int i = 0; i < 8; i++) ld(32'(i * 4), 1'b0);
        idle(4, 1'b0);

        // Reset with loads pending, then a fresh load.
        ld(32'h8, 1'b0);
        ld(32'hC, 1'b0);
        step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
        idle(3, 1'b0);
        ld(32'h100, 1'b0);
        idle(3, 1'b0);
        check("t6_after_reset", last_rd[0], 32'h11223344);

        // Randomized traffic over 16 aliased words.
        for (int n = 0; n < 800; n++) begin
            tmp  = $urandom();
            widx = 4'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                 {tmp[31:12], 6'd0, widx, tmp[1:0]}, 4'($urandom()), $urandom(),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 149) == 0);
        end
        idle(12, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
